// File: rtl/gray_delta_tracker.sv
// Samples a 4-bit Gray-coded position, converts it to binary, and accumulates modulo-16 forward steps.
// Back-to-back samples must differ in at most one bit, otherwise a fault is latched until clear.
module gray_delta_tracker #(
   parameter int ACC_W = 12,
   parameter int ERR_W = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [3:0]       g_in,
   input  logic             sample,
   input  logic             clear,
   output logic [3:0]       bin_out,
   output logic [3:0]       delta,
   output logic             delta_valid,
   output logic [ACC_W-1:0] total,
   output logic             step_err,
   output logic [ERR_W-1:0] err_count
);

   typedef enum logic [1:0] {EMPTY, RUN, FAULT} state_t;

   state_t           state, state_next;
   logic [3:0]       ref_gray, ref_next;
   logic [3:0]       bin_new, bin_next, delta_next, diff;
   logic [ACC_W-1:0] total_next;
   logic             dv_next, err_next;
   logic [ERR_W-1:0] cnt_next;
   logic             last_acc, acc_next;
   logic             multi_bit, fault_hit;

   assign bin_new   = {g_in[3], ^g_in[3:2], ^g_in[3:1], ^g_in[3:0]};
   assign diff      = bin_new - bin_out;
   assign multi_bit = ($countones(g_in ^ ref_gray) > 1);
   // Hamming is only enforced when the previous accepted sample was on the immediately preceding edge.
   assign fault_hit = (state == RUN) && sample && last_acc && multi_bit;

   always_ff @(posedge clock) begin
      if (!reset_n) state <= EMPTY;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (clear) begin
         state_next = EMPTY;
      end else begin
         case (state)
            EMPTY:   if (sample) state_next = RUN;
            RUN:     if (fault_hit) state_next = FAULT;
            FAULT:   state_next = FAULT;
            default: state_next = EMPTY;
         endcase
      end
   end

   always_comb begin
      ref_next   = ref_gray;
      bin_next   = bin_out;
      delta_next = delta;
      dv_next    = 1'b0;
      total_next = total;
      err_next   = step_err;
      cnt_next   = err_count;
      acc_next   = 1'b0;
      if (clear) begin
         ref_next   = 4'd0;
         bin_next   = 4'd0;
         delta_next = 4'd0;
         total_next = '0;
         err_next   = 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               if (sample) begin
                  ref_next = g_in;
                  bin_next = bin_new;
                  acc_next = 1'b1;
               end
            end
            RUN: begin
               if (fault_hit) begin
                  err_next = 1'b1;
                  cnt_next = (err_count == '1) ? err_count : err_count + ERR_W'(1);
               end else if (sample) begin
                  ref_next   = g_in;
                  bin_next   = bin_new;
                  delta_next = diff;
                  dv_next    = 1'b1;
                  total_next = total + ACC_W'(diff);
                  acc_next   = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         ref_gray    <= 4'd0;
         bin_out     <= 4'd0;
         delta       <= 4'd0;
         delta_valid <= 1'b0;
         total       <= '0;
         step_err    <= 1'b0;
         err_count   <= '0;
         last_acc    <= 1'b0;
      end else begin
         ref_gray    <= ref_next;
         bin_out     <= bin_next;
         delta       <= delta_next;
         delta_valid <= dv_next;
         total       <= total_next;
         step_err    <= err_next;
         err_count   <= cnt_next;
         last_acc    <= acc_next;
      end
   end

endmodule

// File: tb/tb_gray_delta_tracker.sv
// Scoreboard bench for gray_delta_tracker: a default-width instance and a narrow instance (ACC_W=4, ERR_W=3)
// share one stimulus stream; a behavioural model predicts every cycle's outputs.
module tb_gray_delta_tracker;

   localparam int ERR_W4 = 3;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       reset_n, sample, clear;
   logic [3:0] g_in;

   logic [3:0]  bin_a, delta_a, bin_b, delta_b;
   logic        dv_a, err_a, dv_b, err_b;
   logic [11:0] total_a;
   logic [7:0]  cnt_a;
   logic [3:0]  total_b;
   logic [ERR_W4-1:0] cnt_b;

   gray_delta_tracker dut_wide (
      .clock(clock), .reset_n(reset_n), .g_in(g_in), .sample(sample), .clear(clear),
      .bin_out(bin_a), .delta(delta_a), .delta_valid(dv_a), .total(total_a),
      .step_err(err_a), .err_count(cnt_a)
   );

   gray_delta_tracker #(.ACC_W(4), .ERR_W(ERR_W4)) dut_narrow (
      .clock(clock), .reset_n(reset_n), .g_in(g_in), .sample(sample), .clear(clear),
      .bin_out(bin_b), .delta(delta_b), .delta_valid(dv_b), .total(total_b),
      .step_err(err_b), .err_count(cnt_b)
   );

   typedef struct {
      int bin;
      int delta;
      int dv;
      int total;
      int err;
      int cnt;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   driver_done = 1'b0;

   bit         have_ref, faulted, last_acc;
   int         m_bin, m_delta, m_dv, m_total, m_err, m_cnt;
   logic [3:0] m_prev_g;
   logic [3:0] cur_g;

   // Binary position whose Gray encoding equals g, found by search rather than XOR folding.
   function automatic int gray_to_int(input logic [3:0] g);
      for (int i = 0; i < 16; i++)
         if (4'(i ^ (i >> 1)) == g) return i;
      return -1;
   endfunction

   function automatic int min_int(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic model_step();
      bit accepted = 1'b0;
      int nb;
      if (!reset_n) begin
         have_ref = 0; faulted = 0; last_acc = 0;
         m_bin = 0; m_delta = 0; m_dv = 0; m_total = 0; m_err = 0; m_cnt = 0; m_prev_g = 4'd0;
      end else if (clear) begin
         have_ref = 0; faulted = 0; last_acc = 0;
         m_bin = 0; m_delta = 0; m_dv = 0; m_total = 0; m_err = 0;
      end else begin
         m_dv = 0;
         if (sample && !faulted) begin
            nb = gray_to_int(g_in);
            if (!have_ref) begin
               have_ref = 1; m_bin = nb; m_prev_g = g_in; accepted = 1;
            end else if (last_acc && $countones(g_in ^ m_prev_g) > 1) begin
               faulted = 1; m_err = 1; m_cnt = m_cnt + 1;
            end else begin
               m_delta = (nb - m_bin + 16) % 16;
               m_total = (m_total + m_delta) % 4096;
               m_dv = 1; m_bin = nb; m_prev_g = g_in; accepted = 1;
            end
         end
         last_acc = accepted;
      end
   endtask

   task automatic applyStimulus(input logic r, input logic c, input logic s, input logic [3:0] g);
      exp_t e;
      reset_n = r; clear = c; sample = s; g_in = g;
      @(posedge clock);
      model_step();
      e.bin = m_bin; e.delta = m_delta; e.dv = m_dv; e.total = m_total; e.err = m_err; e.cnt = m_cnt;
      sb.push_back(e);
      #2;
   endtask

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      check("wide.bin_out",     int'(bin_a),   e.bin);
      check("wide.delta",       int'(delta_a), e.delta);
      check("wide.delta_valid", int'(dv_a),    e.dv);
      check("wide.total",       int'(total_a), e.total % 4096);
      check("wide.step_err",    int'(err_a),   e.err);
      check("wide.err_count",   int'(cnt_a),   min_int(e.cnt, 255));
      check("narrow.bin_out",     int'(bin_b),   e.bin);
      check("narrow.delta",       int'(delta_b), e.delta);
      check("narrow.delta_valid", int'(dv_b),    e.dv);
      check("narrow.total",       int'(total_b), e.total % 16);
      check("narrow.step_err",    int'(err_b),   e.err);
      check("narrow.err_count",   int'(cnt_b),   min_int(e.cnt, (1 << ERR_W4) - 1));
   endtask

   // Monitor: outputs settle after each rising edge, so compare on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] simulation timed out");
   end

   initial begin
      reset_n = 1'b0; clear = 1'b0; sample = 1'b0; g_in = 4'd0; cur_g = 4'd0;

      // Reset held with sample asserted, then prime and a one-step advance.
      applyStimulus(0, 0, 1, 4'b0101);
      applyStimulus(0, 0, 1, 4'b0101);
      applyStimulus(1, 0, 1, 4'b0011);
      applyStimulus(1, 0, 1, 4'b0010);

      // Wrap 15 -> 0 and a zero-step repeat.
      applyStimulus(1, 1, 0, 4'b0000);
      applyStimulus(1, 0, 1, 4'b1000);
      applyStimulus(1, 0, 1, 4'b0000);
      applyStimulus(1, 0, 1, 4'b0000);

      // Non-consecutive multi-bit jump is legal.
      for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 4'b0000);
      applyStimulus(1, 0, 1, 4'b0111);

      // Fault on a consecutive two-bit change, ignored samples, clear racing a sample.
      for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 4'b0000);
      applyStimulus(1, 0, 1, 4'b0000);
      applyStimulus(1, 0, 1, 4'b0011);
      applyStimulus(1, 0, 1, 4'b0001);
      applyStimulus(1, 0, 1, 4'b0000);
      applyStimulus(1, 1, 1, 4'b0110);
      applyStimulus(1, 0, 0, 4'b0110);
      applyStimulus(1, 0, 1, 4'b0110);

      // Seventeen legal counter steps after priming: the narrow total wraps at the 16th delta.
      applyStimulus(1, 1, 0, 4'b0000);
      applyStimulus(1, 0, 1, 4'b0000);
      for (int i = 1; i <= 17; i++) applyStimulus(1, 0, 1, 4'((i % 16) ^ ((i % 16) >> 1)));

      // Randomised traffic: mostly single-bit moves, occasional jumps, clears and resets.
      cur_g = 4'd0;
      for (int i = 0; i < 600; i++) begin
         logic r, c, s;
         r = ($urandom_range(0, 99) != 0);
         c = ($urandom_range(0, 24) == 0);
         s = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 9))
            0, 1:    cur_g = 4'($urandom_range(0, 15));
            2:       ;
            default: cur_g = cur_g ^ (4'b0001 << $urandom_range(0, 3));
         endcase
         applyStimulus(r, c, s, cur_g);
      end

      applyStimulus(1, 0, 0, cur_g);
      @(negedge clock);
      @(negedge clock);
      check("scoreboard_drained", sb.size(), 0);
      driver_done = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
